// File: rtl/ps2_event_rx_pkg.sv
// Shared PS/2 receiver types: prefix bytes, prefix FSM states and the event word.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} prefix_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // A frame is {stop, parity, data[7:0], start}; good when start=0, stop=1
  // and data plus parity carry an odd number of ones.
  function automatic logic frame_ok(input logic [10:0] frame);
    return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_event_rx_sync_fifo.sv
// First-word-fall-through FIFO; the head entry is held in an output register
// so the storage array is only ever read synchronously.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_next, wr_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [WIDTH-1:0] head_reg;
  logic             full, empty, do_wr, do_rd;

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_rd = rd_en && !empty;
  // A same-cycle pop frees the slot, so a push to a full FIFO is still taken.
  assign do_wr = wr_en && (!full || do_rd);
  assign drop  = wr_en && full && !do_rd;

  // Next pointer and occupancy values shared by the registers below.
  always_comb begin
    wr_ptr_next = do_wr ? wr_ptr_reg + (AW+1)'(1) : wr_ptr_reg;
    rd_ptr_next = do_rd ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (do_wr && !do_rd)
      count_next = count_reg + (AW+1)'(1);
    else if (!do_wr && do_rd)
      count_next = count_reg - (AW+1)'(1);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next == '0)
        head_reg <= '0;
      else if (do_wr && (wr_ptr_reg == rd_ptr_next))
        head_reg <= wr_data;   // the entry being written becomes the head
      else
        head_reg <= mem[rd_ptr_next[AW-1:0]];
    end
  end

  assign rd_data = head_reg;
  assign valid   = (count_reg != '0);
  assign count   = count_reg;

endmodule

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: synchronises the line, collects 11-bit frames,
// folds E0/F0 prefixes into {ext, brk, code} events and queues them.
module ps2_event_rx
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 50000,
  parameter int ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   rd_en,
  output logic [9:0]             ev_data,
  output logic                   ev_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic                   frame_err,
  output logic [ERR_W-1:0]       err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] clk_sync_reg, data_sync_reg;
  logic                   clk_prev_reg, fall, clk_s, data_s;
  logic [9:0]             shift_reg;
  logic [10:0]            frame;
  logic [3:0]             bit_cnt_reg;
  logic [TW-1:0]          idle_cnt_reg;
  logic                   frame_done, timeout, byte_good, byte_bad;
  logic [7:0]             code;

  prefix_state_t state_reg, state_next;
  ps2_event_t    push_data_reg, push_data_next;
  logic          push_reg, push_next, frame_err_reg, frame_err_next;
  logic          overflow_reg, fifo_drop;
  logic [ERR_W-1:0] err_count_reg;

  // Synchroniser chains; the line idles high, so stages reset to 1.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          clk_sync_reg[gi]  <= 1'b1;
          data_sync_reg[gi] <= 1'b1;
        end else begin
          clk_sync_reg[gi]  <= ps2_clk;
          data_sync_reg[gi] <= ps2_data;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          clk_sync_reg[gi]  <= 1'b1;
          data_sync_reg[gi] <= 1'b1;
        end else begin
          clk_sync_reg[gi]  <= clk_sync_reg[gi-1];
          data_sync_reg[gi] <= data_sync_reg[gi-1];
        end
      end
    end
  end

  assign clk_s      = clk_sync_reg[SYNC_STAGES-1];
  assign data_s     = data_sync_reg[SYNC_STAGES-1];
  assign fall       = clk_prev_reg && !clk_s;
  assign frame      = {data_s, shift_reg};
  assign frame_done = fall && (bit_cnt_reg == 4'd10);
  assign timeout    = !fall && (bit_cnt_reg != 4'd0) && (idle_cnt_reg == TW'(TIMEOUT));
  assign byte_good  = frame_done && frame_ok(frame);
  assign byte_bad   = frame_done && !frame_ok(frame);
  assign code       = frame[8:1];

  // Frame collection: shift LSB-first on each falling edge, abandon stale frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_reg <= 1'b1;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
    end else begin
      clk_prev_reg <= clk_s;
      if (fall) begin
        shift_reg    <= frame[10:1];
        idle_cnt_reg <= '0;
        bit_cnt_reg  <= frame_done ? 4'd0 : bit_cnt_reg + 4'd1;
      end else if (timeout) begin
        bit_cnt_reg  <= '0;
        idle_cnt_reg <= '0;
      end else if (bit_cnt_reg != 4'd0) begin
        idle_cnt_reg <= idle_cnt_reg + TW'(1);
      end
    end
  end

  // Prefix FSM: decide next state, event push and error pulse per received byte.
  always_comb begin
    state_next     = state_reg;
    push_next      = 1'b0;
    push_data_next = '0;
    frame_err_next = 1'b0;
    if (timeout || byte_bad) begin
      state_next     = IDLE;
      frame_err_next = 1'b1;
    end else if (byte_good) begin
      unique case (state_reg)
        IDLE: begin
          if (code == PS2_EXT)      state_next = EXT;
          else if (code == PS2_BRK) state_next = BRK;
          else begin
            push_next      = 1'b1;
            push_data_next = '{ext: 1'b0, brk: 1'b0, code: code};
          end
        end
        EXT: begin
          if (code == PS2_BRK)      state_next = EXTBRK;
          else if (code == PS2_EXT) state_next = EXT;
          else begin
            push_next      = 1'b1;
            push_data_next = '{ext: 1'b1, brk: 1'b0, code: code};
            state_next     = IDLE;
          end
        end
        BRK, EXTBRK: begin
          state_next = IDLE;
          // A prefix after F0 is a protocol error and is reported like a bad frame.
          if (code == PS2_EXT || code == PS2_BRK) frame_err_next = 1'b1;
          else begin
            push_next      = 1'b1;
            push_data_next = '{ext: (state_reg == EXTBRK), brk: 1'b1, code: code};
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Prefix FSM state, registered push and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      push_reg      <= push_next;
      push_data_reg <= push_data_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Sticky overflow (a drop beats clear) and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      if (fifo_drop)    overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;
      if (frame_err_reg && (err_count_reg != '1))
        err_count_reg <= err_count_reg + ERR_W'(1);
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_reg),
    .wr_data (push_data_reg),
    .rd_en   (rd_en),
    .rd_data (ev_data),
    .valid   (ev_valid),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_ps2_event_rx.sv
// Bench for ps2_event_rx: a byte-level model predicts events into a queue,
// and a monitor pops and compares whenever the DUT offers an event.
module tb_ps2_event_rx;

  localparam int DEPTH   = 4;
  localparam int SYNC    = 3;
  localparam int TIMEOUT = 200;
  localparam int ERR_W   = 8;
  localparam int HALF    = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, clr_ovf = 1'b0;
  logic [9:0] ev_data;
  logic ev_valid, overflow, frame_err;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  ps2_event_rx #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .ev_data(ev_data), .ev_valid(ev_valid), .fifo_count(fifo_count),
    .overflow(overflow), .clr_ovf(clr_ovf), .frame_err(frame_err), .err_count(err_count)
  );

  int checks = 0, failures = 0;
  logic [9:0] exp_q[$];
  bit auto_read = 0;
  int pop_req = 0, pop_done = 0;
  int pulses = 0, exp_pulses = 0, exp_err = 0, m_fill = 0;
  bit m_ext = 0, m_brk = 0, exp_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and checks the head whenever reading is enabled or requested.
  always @(negedge clk) begin
    if (frame_err) pulses++;
    if (ev_valid && (auto_read || pop_req != pop_done)) begin
      if (pop_req != pop_done) pop_done++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got 0x%0h expected none", ev_data);
      end else begin
        check("event", {22'd0, ev_data}, {22'd0, exp_q.pop_front()});
      end
      $display("event popped 0x%03h", ev_data);
      rd_en = 1'b1;
    end else begin
      rd_en = 1'b0;
    end
  end

  // ---------------- reference model (byte level, flag based) ----------------
  task automatic note_err();
    exp_pulses++;
    if (exp_err < 255) exp_err++;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic expect_event(input logic [9:0] e);
    if (!auto_read && m_fill == DEPTH) exp_ovf = 1;
    else begin
      exp_q.push_back(e);
      if (!auto_read) m_fill++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) note_err();
    else if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) note_err();
      else if (b == 8'hE0) m_ext = 1;
      else m_brk = 1;
    end else begin
      expect_event({m_ext, m_brk, b});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // ---------------- line driver ----------------
  function automatic logic [10:0] mk(input logic [7:0] b, input bit good);
    logic p;
    p = good ? ~^b : ^b;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Drives n bits; returns right after the last falling edge of ps2_clk.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
      end
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    $display("send byte 0x%02h good=%0d", b, good);
    model_byte(b, good);
    send_bits(mk(b, good), 11);
    end_frame();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    auto_read = 1;
    @(posedge clk); #2;
    while ((exp_q.size() != 0 || ev_valid) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check(name, {31'd0, (n < 3000)}, 32'd1);
    check("drained_count", {29'd0, fifo_count}, 32'd0);
    m_fill = 0;
  endtask

  logic [7:0] ovf_bytes [5];
  logic [7:0] full_bytes [4];

  initial begin
    ovf_bytes  = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
    full_bytes = '{8'h1C, 8'h32, 8'h21, 8'h23};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_ev_data", {22'd0, ev_data}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Latency of a single make code.
    model_byte(8'h1C, 1);
    send_bits(mk(8'h1C, 1), 11);
    repeat (SYNC + 1) @(posedge clk);
    #1 check("lat_early", {31'd0, ev_valid}, 32'd0);
    @(posedge clk);
    #1 check("lat_valid", {31'd0, ev_valid}, 32'd1);
    check("lat_count", {29'd0, fifo_count}, 32'd1);
    end_frame();
    wait_drain("drain_make");
    check("make_valid_low", {31'd0, ev_valid}, 32'd0);

    // Prefix folding.
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    send_byte(8'hE0, 1); send_byte(8'h74, 1);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h74, 1);
    wait_drain("drain_prefix");

    // Bad parity then a good byte.
    send_byte(8'h1C, 0);
    check("parity_pulses", pulses, exp_pulses);
    check("parity_err_count", {24'd0, err_count}, exp_err);
    send_byte(8'h1B, 1);
    wait_drain("drain_parity");

    // Overflow with no reads, then clear.
    auto_read = 0;
    for (int i = 0; i < 5; i++) send_byte(ovf_bytes[i], 1);
    check("ovf_count", {29'd0, fifo_count}, DEPTH);
    check("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
    wait_drain("drain_ovf");
    @(negedge clk) clr_ovf = 1'b1;
    @(negedge clk) clr_ovf = 1'b0;
    exp_ovf = 0;
    @(negedge clk);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Push and pop on the same cycle while full.
    auto_read = 0;
    for (int i = 0; i < 4; i++) send_byte(full_bytes[i], 1);
    check("full_count", {29'd0, fifo_count}, DEPTH);
    m_fill = DEPTH - 1;  // the coincident pop frees a slot
    model_byte(8'h2B, 1);
    send_bits(mk(8'h2B, 1), 11);
    repeat (SYNC + 1) @(posedge clk);
    #1 pop_req++;
    @(posedge clk);
    #1 check("pushpop_count", {29'd0, fifo_count}, DEPTH);
    check("pushpop_ovf", {31'd0, overflow}, 32'd0);
    end_frame();
    wait_drain("drain_pushpop");

    // Partial frame timeout.
    note_err();
    send_bits(mk(8'h2D, 1), 6);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    check("timeout_pulses", pulses, exp_pulses);
    check("timeout_err_count", {24'd0, err_count}, exp_err);
    send_byte(8'h2D, 1);
    wait_drain("drain_timeout");

    // Reset after a break prefix: the flag must not survive.
    send_byte(8'hF0, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_ext = 0; m_brk = 0; exp_err = 0;
    @(negedge clk);
    check("rst2_err_count", {24'd0, err_count}, 32'd0);
    check("rst2_ev_valid", {31'd0, ev_valid}, 32'd0);
    send_byte(8'h1C, 1);
    wait_drain("drain_reset");

    // Random byte streams with occasional parity errors.
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else begin
        b = 8'($urandom_range(1, 255));
        while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(1, 255));
      end
      send_byte(b, $urandom_range(0, 9) != 0);
    end
    wait_drain("drain_random");
    check("random_pulses", pulses, exp_pulses);
    check("random_err_count", {24'd0, err_count}, exp_err);
    check("final_ovf", {31'd0, overflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_event_rx.md
Name: ps2_event_rx

Overview:
- Parametrised PS/2 keyboard receiver that replaces the single-byte receiver-plus-handshake pair.
- Deserialises PS/2 frames and checks start, odd parity and stop bits.
- Folds E0/F0 prefixes into one key event: {ext, brk, code}.
- Buffers events in a first-word-fall-through FIFO with valid/read handshake; downstream ASCII/display logic consumes whole events, not raw bytes.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
SYNC_STAGES, 3, synchroniser flops on ps2_clk and ps2_data; at least 2.
TIMEOUT, 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
rd_en  in  1  pop head event; ignored when ev_valid=0
ev_data  out  10  head event {ext, brk, code[7:0]}
ev_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: an event was dropped because the FIFO was full
clr_ovf  in  1  clears overflow; loses to a same-cycle drop
frame_err  out  1  one-cycle pulse on a bad frame or a timeout
err_count  out  ERR_W  saturating count of frame_err pulses

Behaviour:
- Reset (asynchronous): FIFO empty; ev_valid=0, ev_data=0, fifo_count=0, overflow=0, frame_err=0, err_count=0; bit counter 0; prefix FSM in IDLE.
- Synchroniser and edge detect: ps2_clk passes through SYNC_STAGES flops. A falling edge is a cycle where the previous synced value is 1 and the current is 0. ps2_data is sampled from its synced copy on that edge.
- Frame collection: an 11-bit shift register captures LSB-first. Bit count 0..10.
  - Good frame: start=0, data bits 1..8, odd parity over data+parity, stop=1.
  - Frame completes on the cycle the 11th edge is detected.
- Timeout: an idle counter resets on every falling edge. If the bit count is non-zero and the counter reaches TIMEOUT:
  - bit count returns to 0;
  - frame_err pulses;
  - prefix FSM returns to IDLE.
- Bad frame (start, parity or stop fails): byte discarded, frame_err pulses, prefix FSM returns to IDLE.
- err_count increments on each frame_err pulse and saturates at all-ones.
- Prefix FSM, on each good byte:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {0,0,b}, stay in IDLE.
  - EXT: F0 -> EXTBRK; E0 -> stay in EXT; other -> push {1,0,b}, go to IDLE.
  - BRK: E0 or F0 -> protocol error (treat as a bad frame, go to IDLE); other -> push {0,1,b}, go to IDLE.
  - EXTBRK: E0 or F0 -> protocol error; other -> push {1,1,b}, go to IDLE.
  - Bytes AA (BAT) and FA (ACK) in IDLE are pushed as ordinary events; there is no special casing.
- Latency: a push is registered on the cycle after frame completion. ev_valid rises one cycle later if the FIFO was empty.
- FIFO:
  - Write and read pointers are ($clog2(DEPTH)+1) bits wide, so full and empty are distinguished by the MSB.
  - ev_data always shows the head entry while ev_valid=1.
  - Push while full: event dropped and overflow set. Exception: a pop in the same cycle frees a slot, so both are accepted, there is no overflow and count is unchanged.
  - Push and pop on a non-full, non-empty FIFO: count unchanged.
  - rd_en while empty: no effect.
- A reset mid-frame or mid-prefix discards everything; no partial event is emitted after reset is released.

Decomposition:
- Package ps2_pkg:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0;
  - enum prefix_state_t {IDLE, EXT, BRK, EXTBRK};
  - typedef ps2_event_t {ext, brk, code[7:0]}.
- Sub-module sync_fifo (parameters DEPTH, WIDTH=10) holds pointers, count and FWFT read. The frame receiver and prefix FSM stay in ps2_event_rx.

Test Plan:
- Make 1C -> one event 0x01C; ev_valid high two clk after the 11th edge; rd_en -> ev_valid=0, fifo_count=0.
- Bytes F0 1C -> single event 0x11C. Bytes E0 74 -> 0x274. Bytes E0 F0 74 -> 0x374. No events for prefix bytes alone.
- 1C sent with even parity -> no event; frame_err one pulse; err_count=1. Following good 1B -> 0x01B.
- DEPTH=4, five makes 15 16 1E 26 25 with no reads -> fifo_count=4, overflow=1, reads return 15 16 1E 26. clr_ovf -> overflow=0.
- Six data bits then idle for TIMEOUT cycles -> frame_err pulse, bit count 0. Next full frame 2D -> event 0x02D.
- F0 received, then reset pulsed, then 1C -> event 0x01C (break flag not carried). Push and pop on the same cycle while full -> count stays 4, overflow stays 0.
